update_sequencer: RTL and testbench

- Per-frame scheduler for game-object updaters (paddle, ball, score, ...).
- On each entry into vertical blanking it issues a one-cycle start pulse to each enabled client in fixed index order and waits for that client's done before moving to the next.
- Enforces a per-client timeout and flags frame overrun if active video resumes before the schedule completes.
- Sits beside the hsync/vsync controllers, consumes activeLine and replaces the ad-hoc update counter.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/update_sequencer_timer.sv | 32 +++
 rtl/update_sequencer.sv | 159 +++++++++++++++
 tb/tb_update_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA game slice: sequencer state encoding,
// display timing constants used by the hsync/vsync controllers, and the
// fixed client slots of the per-frame update scheduler.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    WAIT   = 2'd3
  } seq_state_t;

  // 640x480 @ 60 Hz horizontal timing, in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  // 640x480 @ 60 Hz vertical timing, in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Client slots; lower index is updated first within a frame
  localparam int CL_PADDLE = 0;
  localparam int CL_BALL   = 1;
  localparam int CL_SCORE  = 2;

endpackage

// File: rtl/update_sequencer_timer.sv
// Per-client watchdog for the update sequencer. Cleared when a client is
// started, counts while the sequencer waits, and saturates at its last
// count so the expired indication stays stable until the next clear.
module seq_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clck,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] r_count;

  assign o_expired = (r_count == LAST);

  // Wait-cycle counter: clear on start, count while waiting, hold at last
  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/update_sequencer.sv
// Per-frame scheduler for game-object updaters. Each falling edge of
// active_line (entry into blanking) walks the enabled clients in index
// order, pulses start for one cycle and waits for done or a timeout.
// Active video resuming before the walk finishes aborts it and latches
// a sticky overrun flag.
module update_sequencer
  import vga_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                   clck,
  input  logic                   reset,
  input  logic                   active_line,
  input  logic [NUM_CLIENTS-1:0] client_en,
  input  logic [NUM_CLIENTS-1:0] done,
  input  logic                   clear_flags,
  output logic [NUM_CLIENTS-1:0] start,
  output logic                   busy,
  output logic                   timeout_flag,
  output logic [2:0]             timeout_client,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  // index must be able to hold NUM_CLIENTS itself (end-of-schedule marker)
  localparam int IDX_W = $clog2(NUM_CLIENTS + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_CLIENTS);

  seq_state_t             r_state;
  logic [IDX_W-1:0]       r_index;
  logic                   r_prev_active;
  logic [NUM_CLIENTS-1:0] r_start;
  logic                   r_busy;
  logic                   r_timeout_flag;
  logic [2:0]             r_timeout_client;
  logic                   r_overrun;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  logic                   w_trigger;
  logic                   w_rise;
  logic                   w_en_cur;
  logic                   w_done_cur;
  logic [NUM_CLIENTS-1:0] w_onehot;
  logic                   w_timer_clr;
  logic                   w_timer_en;
  logic                   w_timer_expired;

  assign w_trigger   = r_prev_active & ~active_line;
  assign w_rise      = ~r_prev_active & active_line;
  assign w_timer_clr = (r_state == ISSUE);
  assign w_timer_en  = (r_state == WAIT);

  assign start          = r_start;
  assign busy           = r_busy;
  assign timeout_flag   = r_timeout_flag;
  assign timeout_client = r_timeout_client;
  assign overrun        = r_overrun;
  assign frame_count    = r_frame_count;

  // Decode the current client: its enable, its done and its start vector.
  // An index equal to NUM_CLIENTS selects nothing.
  always_comb begin
    w_en_cur   = 1'b0;
    w_done_cur = 1'b0;
    w_onehot   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (r_index == IDX_W'(i)) begin
        w_en_cur    = client_en[i];
        w_done_cur  = done[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seq_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clck     (clck),
    .reset    (reset),
    .i_clr    (w_timer_clr),
    .i_en     (w_timer_en),
    .o_expired(w_timer_expired)
  );

  // Scheduler FSM with registered start/busy/flags/frame counter
  always_ff @(posedge clck or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_index          <= '0;
      r_prev_active    <= 1'b0;
      r_start          <= '0;
      r_busy           <= 1'b0;
      r_timeout_flag   <= 1'b0;
      r_timeout_client <= 3'd0;
      r_overrun        <= 1'b0;
      r_frame_count    <= '0;
    end else begin
      r_prev_active <= active_line;
      r_start       <= '0;

      // clear first so a set in the same cycle wins
      if (clear_flags) begin
        r_timeout_flag <= 1'b0;
        r_overrun      <= 1'b0;
      end

      if (w_rise && (r_state != IDLE)) begin
        // active video came back: abandon the schedule, done/timeout ignored
        r_overrun <= 1'b1;
        r_state   <= IDLE;
        r_index   <= '0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_trigger) begin
              r_state <= SELECT;
              r_index <= '0;
              r_busy  <= 1'b1;
            end
          end
          SELECT: begin
            if (r_index == IDX_END) begin
              r_state       <= IDLE;
              r_busy        <= 1'b0;
              r_frame_count <= r_frame_count + 1'b1;
            end else if (w_en_cur) begin
              r_state <= ISSUE;
              r_start <= w_onehot;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
          ISSUE: begin
            r_state <= WAIT;
          end
          WAIT: begin
            if (w_done_cur) begin
              r_index <= r_index + 1'b1;
              r_state <= SELECT;
            end else if (w_timer_expired) begin
              r_timeout_flag   <= 1'b1;
              r_timeout_client <= 3'(r_index);
              r_index          <= r_index + 1'b1;
              r_state          <= SELECT;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_update_sequencer.sv
// Directed bench for update_sequencer (4 clients, 8-cycle timeout,
// 4-bit frame counter). Cycle c=0 of a frame is the edge on which the
// falling edge of active_line is seen.
module tb_update_sequencer;

  logic       clck;
  logic       reset;
  logic       active_line;
  logic [3:0] client_en;
  logic [3:0] done;
  logic       clear_flags;
  logic [3:0] start;
  logic       busy;
  logic       timeout_flag;
  logic [2:0] timeout_client;
  logic       overrun;
  logic [3:0] frame_count;

  int n_checks;
  int n_errors;

  // per-frame observations
  int p_cyc[16];
  int p_val[16];
  int n_pulse;
  int busy_fall;
  int busy_c0;
  int any_start;

  update_sequencer #(
    .NUM_CLIENTS   (4),
    .TIMEOUT_CYCLES(8),
    .FRAME_CNT_W   (4)
  ) dut (
    .clck          (clck),
    .reset         (reset),
    .active_line   (active_line),
    .client_en     (client_en),
    .done          (done),
    .clear_flags   (clear_flags),
    .start         (start),
    .busy          (busy),
    .timeout_flag  (timeout_flag),
    .timeout_client(timeout_client),
    .overrun       (overrun),
    .frame_count   (frame_count)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  task automatic tick();
    @(posedge clck);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse active_line high for one cycle; the next edge sees the fall.
  task automatic start_frame();
    active_line = 1'b1;
    tick();
    active_line = 1'b0;
  endtask

  // Run ncyc cycles, log start pulses, answer each unmuted start with a
  // one-cycle done two edges after the start edge, optionally raise
  // active_line (with clear_flags) after observation rise_at.
  task automatic run_frame(input int ncyc, input logic [3:0] mute, input int rise_at);
    int pend[4];
    for (int k = 0; k < 4; k++) pend[k] = -1;
    n_pulse   = 0;
    busy_fall = -1;
    busy_c0   = 0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      if (c == 0) busy_c0 = int'(busy);
      if (start !== 4'b0000) begin
        if (n_pulse < 16) begin
          p_cyc[n_pulse] = c;
          p_val[n_pulse] = int'(start);
        end
        n_pulse++;
        for (int k = 0; k < 4; k++)
          if (start[k] && !mute[k]) pend[k] = c + 1;
      end
      if (busy === 1'b0 && busy_fall < 0) busy_fall = c;
      done = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        if (pend[k] == c) begin
          done[k] = 1'b1;
          pend[k] = -1;
        end
      end
      clear_flags = (c == rise_at);
      if (c == rise_at) active_line = 1'b1;
    end
    done        = 4'b0000;
    clear_flags = 1'b0;
  endtask

  task automatic check_pulses(input string tag, input int n,
                              input int c0, input int v0, input int c1, input int v1,
                              input int c2, input int v2, input int c3, input int v3);
    int ec[4];
    int ev[4];
    ec = '{c0, c1, c2, c3};
    ev = '{v0, v1, v2, v3};
    check({tag, "_npulse"}, n_pulse, n);
    for (int i = 0; i < n && i < 4; i++) begin
      check($sformatf("%s_p%0d_cyc", tag, i), p_cyc[i], ec[i]);
      check($sformatf("%s_p%0d_val", tag, i), p_val[i], ev[i]);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    active_line = 1'b0;
    client_en   = 4'b0000;
    done        = 4'b0000;
    clear_flags = 1'b0;

    // reset state
    #12;
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_tflag", timeout_flag, 0);
    check("rst_tclient", timeout_client, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fcount", frame_count, 0);
    reset = 1'b0;

    // power-up with active_line low: nothing happens
    client_en = 4'b1111;
    any_start = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (start !== 4'b0000 || busy !== 1'b0) any_start = 1;
    end
    check("powerup_idle", any_start, 0);

    // all clients enabled, done two edges after each start
    start_frame();
    run_frame(16, 4'b0000, -1);
    check("all_busy_c0", busy_c0, 1);
    check_pulses("all", 4, 1, 1, 4, 2, 7, 4, 10, 8);
    check("all_busy_fall", busy_fall, 13);
    check("all_fcount", frame_count, 1);
    check("all_tflag", timeout_flag, 0);

    // clients 0 and 2 enabled only
    client_en = 4'b0101;
    start_frame();
    run_frame(14, 4'b0000, -1);
    check_pulses("sparse", 2, 1, 1, 5, 4, 0, 0, 0, 0);
    check("sparse_busy_fall", busy_fall, 9);
    check("sparse_fcount", frame_count, 2);

    // client 1 never answers: skipped after 8 wait cycles
    client_en = 4'b1111;
    start_frame();
    run_frame(24, 4'b0010, -1);
    check_pulses("tmo", 4, 1, 1, 4, 2, 14, 4, 17, 8);
    check("tmo_busy_fall", busy_fall, 20);
    check("tmo_flag", timeout_flag, 1);
    check("tmo_client", timeout_client, 1);
    check("tmo_fcount", frame_count, 3);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("tmo_cleared", timeout_flag, 0);

    // active video returns while waiting on client 2 (clear_flags same edge)
    start_frame();
    run_frame(16, 4'b0100, 9);
    check_pulses("ovr", 3, 1, 1, 4, 2, 7, 4, 0, 0);
    check("ovr_busy_fall", busy_fall, 10);
    check("ovr_flag", overrun, 1);
    check("ovr_fcount", frame_count, 3);
    check("ovr_tflag", timeout_flag, 0);
    // late done from the aborted client has no effect
    done      = 4'b0100;
    any_start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (start !== 4'b0000 || busy !== 1'b0) any_start = 1;
    end
    done = 4'b0000;
    check("ovr_late_done", any_start, 0);
    check("ovr_late_fcount", frame_count, 3);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ovr_cleared", overrun, 0);

    // reset asserted between edges while waiting on client 0
    start_frame();
    run_frame(5, 4'b1111, -1);
    check("midwait_busy", busy, 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_start", start, 0);
    check("arst_busy", busy, 0);
    check("arst_tclient", timeout_client, 0);
    check("arst_fcount", frame_count, 0);
    #2;
    reset = 1'b0;
    any_start = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (start !== 4'b0000 || busy !== 1'b0) any_start = 1;
    end
    check("arst_no_start", any_start, 0);

    // all clients disabled, 17 frames wrap the 4-bit counter to 1
    client_en = 4'b0000;
    for (int f = 0; f < 17; f++) begin
      start_frame();
      run_frame(8, 4'b0000, -1);
      if (f == 0) begin
        check("dis_npulse", n_pulse, 0);
        check("dis_busy_fall", busy_fall, 5);
        check("dis_fcount", frame_count, 1);
      end
      if (f == 15) check("wrap_zero", frame_count, 0);
    end
    check("wrap_fcount", frame_count, 1);
    check("wrap_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
